// File: rtl/mac_pkg.sv
// Shared definitions for the multiply-accumulate result block:
// FSM state encoding and default word widths.
package mac_pkg;

    localparam int MAC_BITWIDTH  = 32;
    localparam int MAC_ACC_WIDTH = 40;
    localparam int MAC_LEN_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_BIAS  = 2'd2,
        ST_OUT   = 2'd3
    } state_e;

endpackage

// File: rtl/sat_relu.sv
// Clamps a wide signed accumulator to a BITWIDTH signed word, flags clamping,
// then optionally zeroes negative results (ReLU). Purely combinational.
module sat_relu #(
    parameter int BITWIDTH  = 32,
    parameter int ACC_WIDTH = 40
) (
    input  logic [ACC_WIDTH-1:0] acc_i,
    input  logic                 relu_en_i,
    output logic [BITWIDTH-1:0]  result_o,
    output logic                 ovf_o
);

    localparam int HI = ACC_WIDTH - BITWIDTH + 1;

    logic [HI-1:0]       upper_s;
    logic                fits_s;
    logic [BITWIDTH-1:0] sat_s;

    // The value fits iff every bit from the result sign upwards is identical.
    assign upper_s = acc_i[ACC_WIDTH-1 -: HI];
    assign fits_s  = (upper_s == {HI{1'b0}}) || (upper_s == {HI{1'b1}});

    // Saturate toward the sign of the accumulator when it does not fit
    always_comb begin
        sat_s = acc_i[BITWIDTH-1:0];
        ovf_o = 1'b0;
        if (!fits_s) begin
            ovf_o = 1'b1;
            if (acc_i[ACC_WIDTH-1]) begin
                sat_s = {1'b1, {(BITWIDTH-1){1'b0}}};
            end else begin
                sat_s = {1'b0, {(BITWIDTH-1){1'b1}}};
            end
        end else begin
            sat_s = acc_i[BITWIDTH-1:0];
        end
    end

    // ReLU after saturation; the overflow flag is left untouched
    always_comb begin
        result_o = sat_s;
        if (relu_en_i && sat_s[BITWIDTH-1]) begin
            result_o = {BITWIDTH{1'b0}};
        end else begin
            result_o = sat_s;
        end
    end

endmodule

// File: rtl/mac_accum.sv
// Dot-product accumulator: sums len signed products, adds a bias, then
// presents a saturated (optionally ReLU'd) result through a valid/ready port.
module mac_accum #(
    parameter int BITWIDTH  = mac_pkg::MAC_BITWIDTH,
    parameter int ACC_WIDTH = mac_pkg::MAC_ACC_WIDTH,
    parameter int LEN_WIDTH = mac_pkg::MAC_LEN_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 start_i,
    input  logic [LEN_WIDTH-1:0] len_i,
    input  logic [BITWIDTH-1:0]  bias_i,
    input  logic                 relu_en_i,
    input  logic                 prod_valid_i,
    input  logic [BITWIDTH-1:0]  prod_i,
    output logic                 prod_ready_o,
    output logic                 result_valid_o,
    input  logic                 result_ready_i,
    output logic [BITWIDTH-1:0]  result_o,
    output logic                 ovf_o,
    output logic                 busy_o
);

    import mac_pkg::*;

    localparam int EXT = ACC_WIDTH - BITWIDTH;

    state_e               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [BITWIDTH-1:0]  bias_q, bias_d;
    logic                 relu_q, relu_d;
    logic [BITWIDTH-1:0]  result_q, result_d;
    logic                 ovf_q, ovf_d;
    logic                 result_valid_q, result_valid_d;
    logic                 prod_ready_q, prod_ready_d;
    logic                 busy_q, busy_d;

    logic [ACC_WIDTH-1:0] prod_sum_s;
    logic [ACC_WIDTH-1:0] bias_sum_s;
    logic [LEN_WIDTH-1:0] cnt_inc_s;
    logic [BITWIDTH-1:0]  sat_result_s;
    logic                 sat_ovf_s;

    assign prod_sum_s = acc_q + {{EXT{prod_i[BITWIDTH-1]}}, prod_i};
    assign bias_sum_s = acc_q + {{EXT{bias_q[BITWIDTH-1]}}, bias_q};
    assign cnt_inc_s  = cnt_q + {{(LEN_WIDTH-1){1'b0}}, 1'b1};

    // The result is taken from the biased sum so it is ready on entry to OUT.
    sat_relu #(
        .BITWIDTH  (BITWIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_sat_relu (
        .acc_i     (bias_sum_s),
        .relu_en_i (relu_q),
        .result_o  (sat_result_s),
        .ovf_o     (sat_ovf_s)
    );

    // Next-state and datapath update for the job sequencer
    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        cnt_d          = cnt_q;
        len_d          = len_q;
        bias_d         = bias_q;
        relu_d         = relu_q;
        result_d       = result_q;
        ovf_d          = ovf_q;
        result_valid_d = result_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    len_d   = len_i;
                    bias_d  = bias_i;
                    relu_d  = relu_en_i;
                    acc_d   = {ACC_WIDTH{1'b0}};
                    cnt_d   = {LEN_WIDTH{1'b0}};
                    state_d = (len_i != {LEN_WIDTH{1'b0}}) ? ST_ACCUM : ST_BIAS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (prod_valid_i && prod_ready_q) begin
                    acc_d = prod_sum_s;
                    cnt_d = cnt_inc_s;
                    if (cnt_inc_s == len_q) begin
                        state_d = ST_BIAS;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            ST_BIAS: begin
                acc_d          = bias_sum_s;
                result_d       = sat_result_s;
                ovf_d          = sat_ovf_s;
                result_valid_d = 1'b1;
                state_d        = ST_OUT;
            end
            ST_OUT: begin
                if (result_ready_i) begin
                    result_valid_d = 1'b0;
                    state_d        = ST_IDLE;
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: begin
                result_valid_d = 1'b0;
                state_d        = ST_IDLE;
            end
        endcase
        prod_ready_d = (state_d == ST_ACCUM);
        busy_d       = (state_d != ST_IDLE);
    end

    // State and output registers; reset drops any job in flight
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q        <= ST_IDLE;
            acc_q          <= {ACC_WIDTH{1'b0}};
            cnt_q          <= {LEN_WIDTH{1'b0}};
            len_q          <= {LEN_WIDTH{1'b0}};
            bias_q         <= {BITWIDTH{1'b0}};
            relu_q         <= 1'b0;
            result_q       <= {BITWIDTH{1'b0}};
            ovf_q          <= 1'b0;
            result_valid_q <= 1'b0;
            prod_ready_q   <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            cnt_q          <= cnt_d;
            len_q          <= len_d;
            bias_q         <= bias_d;
            relu_q         <= relu_d;
            result_q       <= result_d;
            ovf_q          <= ovf_d;
            result_valid_q <= result_valid_d;
            prod_ready_q   <= prod_ready_d;
            busy_q         <= busy_d;
        end
    end

    assign prod_ready_o   = prod_ready_q;
    assign result_valid_o = result_valid_q;
    assign result_o       = result_q;
    assign ovf_o          = ovf_q;
    assign busy_o         = busy_q;

endmodule
